// File: rtl/filter_mode_ctrl.sv
// Frame-synchronous filter mode controller: queues mode requests and commits them
// on frame boundaries, driving one-hot filter enables; optional auto-cycling demo.
module filter_mode_ctrl #(
   parameter  int NUM_FILT    = 4,
   parameter  int DEMO_FRAMES = 60,
   localparam int MW          = $clog2(NUM_FILT + 1)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                frame_en,
   input  logic                btn_next,
   input  logic                btn_prev,
   input  logic                btn_demo,
   input  logic                cfg_req,
   input  logic [MW-1:0]       cfg_sel,
   output logic                cfg_ack,
   output logic                cfg_err,
   output logic [NUM_FILT-1:0] filt_en,
   output logic [MW-1:0]       cur_mode,
   output logic                pending,
   output logic                demo_active
);

   localparam int DW = (DEMO_FRAMES > 1) ? $clog2(DEMO_FRAMES) : 1;
   localparam logic [MW-1:0] MAX_MODE = MW'(NUM_FILT);
   localparam logic [DW-1:0] DLAST    = DW'(DEMO_FRAMES - 1);

   typedef enum logic {IDLE, PEND} state_t;

   state_t              state, state_n;
   logic [MW-1:0]       pend_mode, pend_n, cur_n, base;
   logic [DW-1:0]       dcnt, dcnt_n;
   logic                demo_n, ack_n, err_n;
   logic [NUM_FILT-1:0] filt_n;

   function automatic logic [MW-1:0] mode_inc(input logic [MW-1:0] m);
      return (m == MAX_MODE) ? '0 : m + 1'b1;
   endfunction

   function automatic logic [MW-1:0] mode_dec(input logic [MW-1:0] m);
      return (m == '0) ? MAX_MODE : m - 1'b1;
   endfunction

   // Requests pre-empt frame-boundary handling: a request landing on frame_en
   // defers the commit (or demo step) to the following frame.
   always_comb begin
      state_n = state;
      pend_n  = pend_mode;
      cur_n   = cur_mode;
      demo_n  = demo_active;
      dcnt_n  = dcnt;
      ack_n   = 1'b0;
      err_n   = 1'b0;
      base    = (state == PEND) ? pend_mode : cur_mode;

      if (cfg_req) begin
         if (cfg_sel <= MAX_MODE) begin
            ack_n   = 1'b1;
            pend_n  = cfg_sel;
            state_n = PEND;
            demo_n  = 1'b0;
            dcnt_n  = '0;
         end else begin
            err_n = 1'b1;
         end
      end else if (btn_next || btn_prev) begin
         pend_n  = btn_next ? mode_inc(base) : mode_dec(base);
         state_n = PEND;
         demo_n  = 1'b0;
         dcnt_n  = '0;
      end else if (btn_demo) begin
         demo_n = ~demo_active;
         dcnt_n = '0;
         if (!demo_active)
            state_n = IDLE;
      end else if (frame_en) begin
         if (state == PEND) begin
            cur_n   = pend_mode;
            state_n = IDLE;
         end else if (demo_active) begin
            if (dcnt == DLAST) begin
               cur_n  = mode_inc(cur_mode);
               dcnt_n = '0;
            end else begin
               dcnt_n = dcnt + 1'b1;
            end
         end
      end

      filt_n = '0;
      for (int unsigned k = 0; k < NUM_FILT; k++)
         filt_n[k] = (cur_n == MW'(k + 1));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         pend_mode   <= '0;
         cur_mode    <= '0;
         demo_active <= 1'b0;
         dcnt        <= '0;
         cfg_ack     <= 1'b0;
         cfg_err     <= 1'b0;
         filt_en     <= '0;
      end else begin
         state       <= state_n;
         pend_mode   <= pend_n;
         cur_mode    <= cur_n;
         demo_active <= demo_n;
         dcnt        <= dcnt_n;
         cfg_ack     <= ack_n;
         cfg_err     <= err_n;
         filt_en     <= filt_n;
      end
   end

   assign pending = (state == PEND);

endmodule

// File: doc/filter_mode_ctrl.md
# filter_mode_ctrl

Frame-synchronous mode controller for the camera filter chain. It accepts mode-change requests from the push-buttons and from a configuration requester, and holds each change pending until the next frame boundary. It then drives one-hot enables to the filter blocks (grayscale and siblings), so no filter ever switches mid-frame. An optional demo mode auto-cycles the filters every `DEMO_FRAMES` frames.

## Interface
Parameters:
- `NUM_FILT`, 4, number of filter blocks driven (≥1); mode 0 = bypass, mode k = filter k-1 enabled
- `DEMO_FRAMES`, 60, frames per step in demo mode (≥1)
- `MW` (localparam) = $clog2(NUM_FILT+1), mode width

Ports:
- `clk` in 1 — pixel clock; single clock domain
- `rst` in 1 — reset; asynchronous and active-high
- `frame_en` in 1 — one-cycle pulse at start of each frame
- `btn_next` in 1 — debounced one-cycle pulse: next mode
- `btn_prev` in 1 — debounced one-cycle pulse: previous mode
- `btn_demo` in 1 — debounced one-cycle pulse: toggle demo mode
- `cfg_req` in 1 — direct mode request, sampled when high
- `cfg_sel` in MW — requested mode
- `cfg_ack` out 1 — one-cycle pulse: `cfg_req` accepted
- `cfg_err` out 1 — one-cycle pulse: `cfg_req` rejected (`cfg_sel` > NUM_FILT)
- `filt_en` out NUM_FILT — bit k = enable of filter k; all zero = bypass
- `cur_mode` out MW — committed mode
- `pending` out 1 — change waiting for frame boundary
- `demo_active` out 1 — demo mode running

## Operation
- Registers: `cur_mode`, `pend_mode`, FSM state {IDLE, PEND}, `demo_active`, frame counter `dcnt` (width $clog2(DEMO_FRAMES)).
- Request priority in one cycle: `cfg_req` > `btn_next` > `btn_prev` > `btn_demo`. Lower-priority inputs in the same cycle are dropped.
- Base for next/prev: `pend_mode` in PEND, `cur_mode` in IDLE. Changes accumulate while pending.
- Wrap-around: next from NUM_FILT goes to 0. Prev from 0 goes to NUM_FILT.
- Any accepted next, prev, or valid cfg request:
  - sets `pend_mode`;
  - moves the FSM to PEND;
  - clears `demo_active` and `dcnt`.
- Invalid `cfg_sel`: `cfg_err` pulses and all state is unchanged.
- IDLE + `frame_en`: no mode change, except the demo step below.
- PEND + `frame_en`, no request in the same cycle: `cur_mode` ← `pend_mode`, FSM → IDLE.
- PEND + `frame_en` + request in the same cycle: the request updates `pend_mode`. The FSM stays PEND, and the commit waits for the next `frame_en`.
- `btn_demo` (when it wins priority):
  - Toggles `demo_active` and clears `dcnt`.
  - Entering demo discards any pending change (FSM → IDLE). Leaving demo keeps `cur_mode`.
- Demo step: in demo, each `frame_en` increments `dcnt`. On the `frame_en` where `dcnt` = DEMO_FRAMES-1:
  - `cur_mode` ← (`cur_mode`+1) wrapped;
  - `dcnt` ← 0.
- `filt_en` is registered. Bit k is 1 iff `cur_mode` = k+1, so at most one bit is set.
- Reset values: `cur_mode`=0, `pend_mode`=0, state IDLE, `filt_en`=0, `pending`=0, `demo_active`=0, `dcnt`=0, `cfg_ack`=0, `cfg_err`=0.
- Reset mid-PEND drops the pending change. Reset takes effect asynchronously; outputs go to reset values immediately.

## Timing
- All outputs are registered; no combinational input-to-output paths.
- `cfg_ack`/`cfg_err` are high exactly one cycle, in the cycle after `cfg_req` is sampled.
- `pending` goes high the cycle after an accepted request. It drops the cycle after the committing `frame_en`.
- `cur_mode` and `filt_en` update together on the edge that samples `frame_en`, and are visible the following cycle.
- Request-to-effect latency is 1 cycle to one full frame, bounded by the next `frame_en` (or the one after, if the request coincides with `frame_en`).
- Held `cfg_req` is re-sampled every cycle. Requesters must deassert after `cfg_ack`.

## Test plan
- Reset, then `btn_next` at cycle 10, `frame_en` at cycle 50 → `pending`=1 from cycle 11. `filt_en`=0001 and `cur_mode`=1 from cycle 51; `pending`=0 from cycle 51.
- `btn_prev` from mode 0 with NUM_FILT=4, then `frame_en` → `cur_mode`=4, `filt_en`=1000. Four `btn_next` pulses then `frame_en` → `cur_mode`=3.
- `cfg_req` with `cfg_sel`=2 → `cfg_ack` for one cycle, commits at next frame. `cfg_sel`=7 → `cfg_err` for one cycle, `pending` stays 0, mode unchanged.
- `btn_next` in the same cycle as `frame_en` → no commit at that frame; commit at the following `frame_en`. `cfg_req` together with `btn_next` → only the cfg value is applied.
- Demo with DEMO_FRAMES=3 → mode advances 0→1→2→3→4→0 on every 3rd `frame_en`. A `btn_next` during demo → `demo_active`=0 and normal pending commit.
- `rst` asserted while PEND, mid-cycle → outputs zero immediately; the next `frame_en` after release causes no change.
